fifo_rd_packer: RTL and testbench
=================================

FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001: Parameter WIDTH, default 4, bit width of one FIFO read word (rdata).
REQ-002: Parameter PACK, default 2, FIFO words packed per output beat; legal range 2..8.
REQ-003: clk_in  input  1  single clock; all state updates on its rising edge.
REQ-004: reset  input  1  asynchronous, active-high reset.
REQ-005: en  input  1  high permits new FIFO reads; low blocks new reads only.
REQ-006: empty  input  1  FIFO read-side empty flag.
REQ-007: rdata  input  WIDTH  FIFO read data, valid in the cycle after an accepted rd_rq.
REQ-008: rd_rq  output  1  FIFO read request, combinational.
REQ-009: out_data  output  WIDTH*PACK  packed beat; word 0 in bits [WIDTH-1:0], word k in bits [(k+1)*WIDTH-1:k*WIDTH].
REQ-010: out_valid  output  1  out_data holds a complete beat.
REQ-011: out_ready  input  1  downstream accepts the beat when high with out_valid.
REQ-012: out_parity  output  1  even parity of out_data (see Configuration).
REQ-013: word_cnt  output  16  total FIFO words consumed since reset.

Function
REQ-014: The FSM SHALL have three states: FILL, WAIT, OUT; a lane index idx (0..PACK-1) selects the target lane.
REQ-015: In FILL, rd_rq SHALL equal en AND NOT empty; on rd_rq=1, next state is WAIT, otherwise the FSM stays in FILL.
REQ-016: rd_rq SHALL be 0 in WAIT and OUT, so one read is issued at most every two cycles.
REQ-017: In WAIT, rdata SHALL be captured into lane idx, and word_cnt SHALL increment by 1.
REQ-018: In WAIT, if idx = PACK-1, idx SHALL clear to 0 and the FSM SHALL go to OUT; otherwise idx increments and the FSM returns to FILL.
REQ-019: out_valid SHALL be 1 exactly while in OUT, and out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020: In OUT, out_valid AND out_ready SHALL complete the transfer; the next state is FILL, and out_valid is 0 the following cycle.
REQ-021: Lanes not yet rewritten SHALL keep their old values; out_data SHALL change only in WAIT.
REQ-022: en deasserting mid-pack SHALL freeze the pack (idx and lanes held) in FILL; reads resume when en returns to 1.
REQ-023: empty asserting mid-pack SHALL hold the FSM in FILL with rd_rq=0; no partial beat is emitted.
REQ-024: empty and en SHALL have no effect in WAIT or OUT; a capture in WAIT always completes.
REQ-025: word_cnt SHALL wrap from 16'hFFFF to 16'h0000 without saturation.
REQ-026: Latency SHALL be 2*PACK cycles from the first rd_rq of a beat to out_valid=1, with FIFO never empty and en=1.

Reset
REQ-027: reset=1 SHALL immediately force state FILL, idx=0, all lanes 0, out_data=0, out_valid=0, word_cnt=0, out_parity=0.
REQ-028: While reset=1, rd_rq SHALL be 0.
REQ-029: Reset asserted mid-pack or mid-OUT SHALL discard the partial or pending beat; its words are lost and are not re-counted.

Configuration
REQ-030: Macro FIFO_RD_PARITY_EN defined: out_parity SHALL be a register equal to the XOR of all out_data bits, updated with out_data.
REQ-031: Macro FIFO_RD_PARITY_EN undefined: the out_parity port SHALL exist and be tied to constant 0, with no parity logic.

Verification
REQ-032: Default params; FIFO preloaded with 4'h3, 4'hA; en=1, out_ready=1 -> out_data=8'hA3, out_valid high for 1 cycle, word_cnt=2.
REQ-033: Beat 8'hA3 pending, out_ready=0 for 5 cycles -> out_data stays 8'hA3, rd_rq=0, out_valid stays 1; on out_ready=1, transfer completes next edge.
REQ-034: Words 4'h1, then empty for 6 cycles, then 4'hF -> single beat 8'hF1; no out_valid during the gap.
REQ-035: en=0 after the first word 4'h5, held 4 cycles, then en=1 with next word 4'h6 -> beat 8'h65, rd_rq=0 while en=0.
REQ-036: reset pulse after one captured word 4'h7 -> out_data=0, idx=0, word_cnt=0; the next two words 4'h2 and 4'h4 give beat 8'h42.
REQ-037: With FIFO_RD_PARITY_EN, beat 8'hA3 -> out_parity=0; beat 8'h01 -> out_parity=1; without the macro -> out_parity=0 always.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// Packs PACK consecutive FIFO read words into one WIDTH*PACK beat with valid/ready handshake.
// Optional registered even parity on the beat when FIFO_RD_PARITY_EN is defined.
module fifo_rd_packer #(
    parameter int WIDTH = 4,
    parameter int PACK  = 2
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  empty,
    input  logic [WIDTH-1:0]      rdata,
    output logic                  rd_rq,
    output logic [WIDTH*PACK-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_parity,
    output logic [15:0]           word_cnt
);

    localparam int IDX_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PACK - 1);

    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [WIDTH*PACK-1:0] data_q, data_d;
    logic [15:0]           cnt_q, cnt_d;

    // A read is only requested from FILL; the FIFO answers one cycle later, in WAIT.
    assign rd_rq     = (state_q == ST_FILL) & en & ~empty & ~reset;
    assign out_valid = (state_q == ST_OUT);
    assign out_data  = data_q;
    assign word_cnt  = cnt_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_FILL: begin
                if (rd_rq) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                for (int k = 0; k < PACK; k++) begin
                    if (idx_q == IDX_W'(k)) data_d[k*WIDTH +: WIDTH] = rdata;
                end
                cnt_d = cnt_q + 16'd1;
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = ST_OUT;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_FILL;
                end
            end
            ST_OUT: begin
                if (out_ready) state_d = ST_FILL;
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= ST_FILL;
            idx_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef FIFO_RD_PARITY_EN
    logic parity_q;

    // Tracks the beat register so parity always matches the currently held out_data.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^data_d;
        end
    end

    assign out_parity = parity_q;
`else
    assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer (WIDTH=4, PACK=2) with a small FIFO model feeding it.
module tb_fifo_rd_packer;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       en;
    logic       empty;
    logic [3:0] rdata;
    logic       rd_rq;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_parity;
    logic [15:0] word_cnt;

    int checks = 0;
    int errors = 0;

`ifdef FIFO_RD_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic [3:0] mem [0:63];
    int wp = 0;
    int rp = 0;

    assign empty = (wp == rp);

    fifo_rd_packer #(.WIDTH(4), .PACK(2)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .en         (en),
        .empty      (empty),
        .rdata      (rdata),
        .rd_rq      (rd_rq),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_parity (out_parity),
        .word_cnt   (word_cnt)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (rd_rq) begin
            rdata <= mem[rp[5:0]];
            rp    <= rp + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] v);
        mem[wp[5:0]] = v;
        wp = wp + 1;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (!out_valid && n < max_cyc) begin
            step();
            n++;
        end
        chk(tag, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic chk_beat(input string tag, input logic [7:0] d, input logic p, input logic [15:0] cnt);
        chk({tag, "_data"}, {24'd0, out_data}, {24'd0, d});
        chk({tag, "_par"}, {31'd0, out_parity}, {31'd0, PAR_ON & p});
        chk({tag, "_cnt"}, {16'd0, word_cnt}, {16'd0, cnt});
    endtask

    initial begin
        rdata     = '0;
        reset     = 1'b1;
        en        = 1'b1;
        out_ready = 1'b1;
        push(4'h3);
        push(4'hA);
        step();
        step();

        // reset state, with FIFO non-empty and en high
        chk("rst_rd_rq", {31'd0, rd_rq}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_cnt", {16'd0, word_cnt}, 32'd0);
        chk("rst_par", {31'd0, out_parity}, 32'd0);

        // basic beat 8'hA3 and 2*PACK latency
        reset = 1'b0;
        #1;
        chk("t1_rd_rq0", {31'd0, rd_rq}, 32'd1);
        step();
        chk("t1_wait_rd_rq", {31'd0, rd_rq}, 32'd0);
        step();
        chk("t1_rd_rq2", {31'd0, rd_rq}, 32'd1);
        step();
        chk("t1_valid3", {31'd0, out_valid}, 32'd0);
        step();
        chk("t1_valid4", {31'd0, out_valid}, 32'd1);
        chk_beat("t1", 8'hA3, 1'b0, 16'd2);
        step();
        chk("t1_valid_drop", {31'd0, out_valid}, 32'd0);

        // backpressure: beat held while out_ready low, FIFO still has data
        out_ready = 1'b0;
        push(4'h3);
        push(4'hA);
        push(4'hC);
        push(4'hB);
        wait_valid("t2_valid", 20);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_hold_data", {24'd0, out_data}, 32'hA3);
            chk("t2_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t2_hold_rd_rq", {31'd0, rd_rq}, 32'd0);
        end
        chk_beat("t2a", 8'hA3, 1'b0, 16'd4);
        out_ready = 1'b1;
        step();
        chk("t2_xfer", {31'd0, out_valid}, 32'd0);
        wait_valid("t2b_valid", 20);
        chk_beat("t2b", 8'hBC, 1'b1, 16'd6);
        step();
        chk("t2b_drop", {31'd0, out_valid}, 32'd0);

        // empty gap mid-pack
        push(4'h1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t3_gap_valid", {31'd0, out_valid}, 32'd0);
        end
        chk("t3_gap_rd_rq", {31'd0, rd_rq}, 32'd0);
        push(4'hF);
        wait_valid("t3_valid", 20);
        chk_beat("t3", 8'hF1, 1'b1, 16'd8);
        step();

        // en low mid-pack freezes the pack
        push(4'h5);
        step();
        en = 1'b0;
        push(4'h6);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("t4_en0_rd_rq", {31'd0, rd_rq}, 32'd0);
            chk("t4_en0_valid", {31'd0, out_valid}, 32'd0);
            step();
        end
        en = 1'b1;
        wait_valid("t4_valid", 20);
        chk_beat("t4", 8'h65, 1'b0, 16'd10);
        step();

        // reset after one captured word discards the partial beat
        push(4'h7);
        step();
        step();
        chk("t5_partial", {24'd0, out_data}, 32'h67);
        chk("t5_partial_cnt", {16'd0, word_cnt}, 32'd11);
        reset = 1'b1;
        #1;
        chk("t5_rst_data", {24'd0, out_data}, 32'd0);
        chk("t5_rst_cnt", {16'd0, word_cnt}, 32'd0);
        chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        push(4'h2);
        push(4'h4);
        step();
        chk("t5_rst_rd_rq", {31'd0, rd_rq}, 32'd0);
        step();
        reset = 1'b0;
        wait_valid("t5_valid", 20);
        chk_beat("t5", 8'h42, 1'b0, 16'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
